divider_sched: RTL and testbench
================================

// Module: divider_sched
// PURPOSE
//  Round-robin scheduler sharing one 16-bit divider datapath among NREQ requesters (lock-in/servo channels).
//  Captures a requester's operands, issues one 'once' pulse, waits for 'done', routes 'out' back to the owner.
//  Sits between per-channel math blocks and the single divider instance; only one operation in flight.
// PARAMETERS
//  NREQ     4   number of requesters, 2..8
//  TIMEOUT  16  cycles in WAIT before abort (used only with DIVSCHED_TIMEOUT_EN)
// PORTS
//  clk        in   1        system clock; all logic on posedge clk
//  rst        in   1        synchronous, active-high reset
//  req        in   NREQ     level request per channel; held with operands until its gnt
//  req_in0    in   16*NREQ  channel i operand A at [16*i+:16]
//  req_in1    in   16*NREQ  channel i operand B at [16*i+:16]
//  req_shift  in   4*NREQ   channel i shift code at [4*i+:4]
//  gnt        out  NREQ     one-hot, 1-cycle pulse: operands of that channel captured
//  rsp_valid  out  NREQ     one-hot, 1-cycle pulse: rsp_data belongs to that channel
//  rsp_data   out  16       result, held until next rsp_valid
//  rsp_err    out  1        qualifies rsp_valid: 1 = aborted by timeout
//  busy       out  1        1 whenever state != IDLE
//  div_once   out  1        1-cycle start pulse to divider
//  div_in0    out  16       registered operand A
//  div_in1    out  16       registered operand B
//  div_shift  out  4        registered shift code
//  div_rst    out  1        1-cycle divider abort; top ORs with rst into divider reset
//  div_done   in   1        divider completion pulse
//  div_out    in   16       divider result, valid with div_done
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, div_*=0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if |req: pick first set req at or after pointer (wrapping); register operands, pulse gnt[i],
//    store owner=i, pointer<=i+1 mod NREQ, go ISSUE. No req: stay.
//  ISSUE: div_once=1 for exactly this cycle; go WAIT.
//  WAIT: on div_done: rsp_data<=div_out, rsp_err<=0, go RESP. div_done in any other state is ignored.
//  RESP: rsp_valid[owner]=1 one cycle; go IDLE. Next grant earliest the cycle after RESP.
//  Latency req->gnt 1 cycle from IDLE; gnt->rsp_valid = divider latency + 3 (shift 0/F: 4; else 10).
//  Fairness: requester waits at most NREQ-1 other operations; req held continuously is never starved.
//  req dropped before gnt: no grant, no effect. req still high after gnt: treated as new request.
//  Simultaneous div_done and rst: rst wins, result discarded, no rsp_valid.
//  Reset mid-operation: FSM to IDLE, owner lost, no response; divider shares rst so it clears too.
//  Operands/outputs are widths fixed at 16/4 bits; no arithmetic beyond pointer wrap mod NREQ.
// CONFIGURATION
//  DIVSCHED_TIMEOUT_EN defined: 8-bit counter cleared on entering WAIT; if TIMEOUT cycles pass with
//    no div_done, pulse div_rst one cycle, rsp_data<=16'h0000, rsp_err<=1, go RESP (owner gets error).
//  Not defined: no counter, div_rst tied 0, rsp_err tied 0, WAIT lasts until div_done.
// STRUCTURE
//  Header divider_sched_defs.vh: state encodings (IDLE=0,ISSUE=1,WAIT=2,RESP=3), DIV_W=16, SHIFT_W=4.
//  Sub-module rr_arbiter (NREQ param): req, pointer in; one-hot grant + index out; purely combinational.
//  Top holds FSM, operand/owner registers, pointer, optional timeout counter.
// TESTING
//  Single req[0], in0=16'h1234, shift=0 -> gnt[0] next cycle, div_once 1 cycle later, rsp_valid[0] with rsp_data=16'h1234, rsp_err=0.
//  req=4'b1111, channel i in1=16'hA000+i, shift=F -> responses in order 0,1,2,3, data A000..A003, never 2 gnts in one op.
//  Pointer=2, req=4'b0011 -> channel 0 granted first, then 1; pointer wraps to 1 then 2.
//  req[1] held continuously with others busy -> gnt[1] within 3 operations; shift=4 op -> gnt->rsp_valid = 10 cycles.
//  rst asserted in WAIT coincident with div_done -> no rsp_valid, busy=0 next cycle, next req granted normally.
//  DIVSCHED_TIMEOUT_EN, TIMEOUT=16, div_done held 0 -> div_rst pulse after 16 WAIT cycles, rsp_err=1, rsp_data=0; without macro stays busy.

Source files
------------

// File: rtl/divider_sched_pkg.sv
// Shared types and constants for the divider scheduler.
// Holds the FSM state encoding, datapath widths and the pointer wrap helper.
package divider_sched_pkg;

   localparam int DIV_W   = 16;
   localparam int SHIFT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Round-robin successor of idx in a ring of n slots.
   function automatic int unsigned rr_next(input int unsigned idx,
                                           input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/divider_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping.
// Ports: req_i/ptr_i in; gnt_o one-hot, idx_o index, vld_o any request.
module divider_sched_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o,
   output logic            vld_o
);

   int c;

   always_comb begin
      c     = 0;
      idx_o = '0;
      vld_o = 1'b0;
      // Scan outward from the pointer; the first hit keeps priority.
      for (int k = 0; k < NREQ; k++) begin
         c = (int'(ptr_i) + k) % NREQ;
         if (!vld_o && req_i[c]) begin
            vld_o = 1'b1;
            idx_o = PW'(c);
         end
      end
      gnt_o = vld_o ? (NREQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/divider_sched.sv
// Round-robin scheduler sharing one 16-bit divider among NREQ requesters.
// Ports: req/req_in0/req_in1/req_shift in, gnt/rsp_* out; div_* to divider.
// Optional abort-on-timeout in WAIT is enabled by DIVSCHED_TIMEOUT_EN.
module divider_sched
   import divider_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [DIV_W*NREQ-1:0]   req_in0,
   input  logic [DIV_W*NREQ-1:0]   req_in1,
   input  logic [SHIFT_W*NREQ-1:0] req_shift,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [DIV_W-1:0]        rsp_data,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    div_once,
   output logic [DIV_W-1:0]        div_in0,
   output logic [DIV_W-1:0]        div_in1,
   output logic [SHIFT_W-1:0]      div_shift,
   output logic                    div_rst,
   input  logic                    div_done,
   input  logic [DIV_W-1:0]        div_out
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e              state_q;
   logic [PW-1:0]       ptr_q, ptr_d, owner_q;
   logic [NREQ-1:0]     gnt_q, rsp_valid_q;
   logic [DIV_W-1:0]    rsp_data_q, in0_q, in1_q;
   logic [SHIFT_W-1:0]  shift_q;
   logic                once_q;

   logic [NREQ-1:0]     arb_gnt;
   logic [PW-1:0]       arb_idx;
   logic                arb_vld;

   divider_sched_rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   assign ptr_d = PW'(rr_next(int'(arb_idx), NREQ));

`ifdef DIVSCHED_TIMEOUT_EN
   logic [7:0] cnt_q;
   logic       rsp_err_q, div_rst_q;
   assign rsp_err = rsp_err_q;
   assign div_rst = div_rst_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign rsp_err = 1'b0;
   assign div_rst = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         in0_q       <= '0;
         in1_q       <= '0;
         shift_q     <= '0;
         once_q      <= 1'b0;
`ifdef DIVSCHED_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_err_q   <= 1'b0;
         div_rst_q   <= 1'b0;
`endif
      end else begin
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         once_q      <= 1'b0;
`ifdef DIVSCHED_TIMEOUT_EN
         div_rst_q   <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (arb_vld) begin
                  in0_q   <= req_in0[DIV_W*int'(arb_idx) +: DIV_W];
                  in1_q   <= req_in1[DIV_W*int'(arb_idx) +: DIV_W];
                  shift_q <= req_shift[SHIFT_W*int'(arb_idx) +: SHIFT_W];
                  gnt_q   <= arb_gnt;
                  owner_q <= arb_idx;
                  ptr_q   <= ptr_d;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               once_q  <= 1'b1;
`ifdef DIVSCHED_TIMEOUT_EN
               cnt_q   <= '0;
`endif
               state_q <= WAIT;
            end
            WAIT: begin
               if (div_done) begin
                  rsp_data_q <= div_out;
`ifdef DIVSCHED_TIMEOUT_EN
                  rsp_err_q  <= 1'b0;
`endif
                  state_q    <= RESP;
               end
`ifdef DIVSCHED_TIMEOUT_EN
               // Count reaches TIMEOUT-1 on the last of TIMEOUT WAIT cycles.
               else if (cnt_q == 8'(TIMEOUT - 1)) begin
                  div_rst_q  <= 1'b1;
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  state_q    <= RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
`endif
            end
            RESP: begin
               rsp_valid_q <= NREQ'(1) << owner_q;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != IDLE);
   assign div_once  = once_q;
   assign div_in0   = in0_q;
   assign div_in1   = in1_q;
   assign div_shift = shift_q;

endmodule

// File: tb/tb_divider_sched.sv
// Directed bench for divider_sched with a behavioural divider stand-in.
// Stand-in: shift 0 -> in0, F -> in1 (latency 1); else in0^in1 (latency 7).
module tb_divider_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] in0_v, in1_v;
   logic [15:0] sh_v;
   logic [3:0]  gnt, rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err, busy, div_once, div_rst;
   logic [15:0] div_in0, div_in1;
   logic [3:0]  div_shift;
   logic        div_done;
   logic [15:0] div_out;

   int n_vec = 0;
   int n_err = 0;
   bit model_en = 1'b1;
   int lat_cnt;
   logic [15:0] pend;

   always #5 clk = ~clk;

   divider_sched #(.NREQ(4), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_in0   (in0_v),
      .req_in1   (in1_v),
      .req_shift (sh_v),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .div_once  (div_once),
      .div_in0   (div_in0),
      .div_in1   (div_in1),
      .div_shift (div_shift),
      .div_rst   (div_rst),
      .div_done  (div_done),
      .div_out   (div_out)
   );

   function automatic int lat_of(input logic [3:0] s);
      return (s == 4'h0 || s == 4'hF) ? 1 : 7;
   endfunction

   function automatic logic [15:0] res_of(input logic [3:0] s,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
      if (s == 4'h0) return a;
      if (s == 4'hF) return b;
      return a ^ b;
   endfunction

   always @(posedge clk) begin
      div_done <= 1'b0;
      if (rst || div_rst) begin
         lat_cnt <= 0;
         div_out <= '0;
      end else if (div_once && model_en) begin
         if (lat_of(div_shift) == 1) begin
            div_done <= 1'b1;
            div_out  <= res_of(div_shift, div_in0, div_in1);
         end else begin
            lat_cnt <= lat_of(div_shift) - 1;
            pend    <= res_of(div_shift, div_in0, div_in1);
         end
      end else if (lat_cnt > 0) begin
         lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) begin
            div_done <= 1'b1;
            div_out  <= pend;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] s);
      in0_v[16*ch +: 16] = a;
      in1_v[16*ch +: 16] = b;
      sh_v[4*ch +: 4]    = s;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_gnt(input int ch, input bit drop);
      int n;
      n = 0;
      while (gnt == 4'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("gnt_seen", (n < 100), 1);
      chk($sformatf("gnt_ch%0d", ch), gnt, 4'b1 << ch);
      if (drop) req[ch] = 1'b0;
   endtask

   task automatic op(input int ch, input logic [15:0] exp_d,
                     input int exp_lat, input bit drop);
      int lat, once_at, gcnt;
      wait_gnt(ch, drop);
      lat = 0;
      once_at = -1;
      gcnt = 0;
      while (rsp_valid == 4'b0 && lat < 100) begin
         @(negedge clk);
         lat++;
         if (div_once && once_at < 0) once_at = lat;
         if (gnt != 4'b0) gcnt++;
      end
      chk("lat", lat, exp_lat);
      chk("once_at", once_at, 1);
      chk("extra_gnt", gcnt, 0);
      chk("rsp_valid", rsp_valid, 4'b1 << ch);
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_err", rsp_err, 0);
   endtask

   initial begin
      int n, bad;
      rst = 1'b1;
      req = '0;
      in0_v = '0;
      in1_v = '0;
      sh_v = '0;
      @(negedge clk);
      do_reset();
      chk("rst_gnt", gnt, 0);
      chk("rst_rv", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_once", div_once, 0);
      chk("rst_in0", div_in0, 0);
      chk("rst_divrst", div_rst, 0);

      // Single requester, shift 0.
      set_ch(0, 16'h1234, 16'h0000, 4'h0);
      req = 4'b0001;
      op(0, 16'h1234, 4, 1);

      // All four, shift F, from pointer 0.
      do_reset();
      for (int i = 0; i < 4; i++)
         set_ch(i, 16'h0000, 16'hA000 + 16'(i), 4'hF);
      req = 4'b1111;
      for (int i = 0; i < 4; i++)
         op(i, 16'hA000 + 16'(i), 4, 1);

      // Move pointer to 2, then 0 and 1 wrap ahead of it.
      set_ch(1, 16'h0101, 16'h0, 4'h0);
      req = 4'b0010;
      op(1, 16'h0101, 4, 1);
      set_ch(0, 16'h0C00, 16'h0, 4'h0);
      req = 4'b0011;
      op(0, 16'h0C00, 4, 1);
      op(1, 16'h0101, 4, 1);
      set_ch(3, 16'h0303, 16'h0, 4'h0);
      req = 4'b1011;
      op(3, 16'h0303, 4, 1);
      req = '0;

      // req[1] held with others busy; shift 4 gives 10-cycle latency.
      req = 4'b0010;
      op(1, 16'h0101, 4, 1);
      set_ch(1, 16'h0F0F, 16'h00FF, 4'h4);
      for (int i = 0; i < 4; i++)
         if (i != 1) set_ch(i, 16'h0, 16'hB000 + 16'(i), 4'hF);
      req = 4'b1111;
      op(2, 16'hB002, 4, 1);
      op(3, 16'hB003, 4, 1);
      op(0, 16'hB000, 4, 0);
      op(1, 16'h0FF0, 10, 1);
      op(0, 16'hB000, 4, 1);

      // Reset coincident with div_done discards the result.
      do_reset();
      set_ch(0, 16'h1111, 16'h2222, 4'h4);
      req = 4'b0001;
      wait_gnt(0, 1);
      n = 0;
      while (!div_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", (n < 100), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstdone_busy", busy, 0);
      chk("rstdone_rv", rsp_valid, 0);
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid != 4'b0) bad++;
      end
      chk("rstdone_norsp", bad, 0);
      set_ch(2, 16'h5A5A, 16'h0, 4'h0);
      req = 4'b0100;
      op(2, 16'h5A5A, 4, 1);

      // Divider never answers.
      model_en = 1'b0;
      set_ch(0, 16'h7777, 16'h0, 4'h0);
      req = 4'b0001;
      wait_gnt(0, 1);
`ifdef DIVSCHED_TIMEOUT_EN
      n = 0;
      while (!div_rst && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("to_divrst_at", n, 17);
      @(negedge clk);
      chk("to_rv", rsp_valid, 4'b0001);
      chk("to_err", rsp_err, 1);
      chk("to_data", rsp_data, 0);
`else
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (!busy || rsp_valid != 4'b0) bad++;
      end
      chk("noto_busy", bad, 0);
`endif
      model_en = 1'b1;
      do_reset();
      chk("end_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
